fp16_block_aligner: RTL

Ingress-side counterpart of the normalization stage.
- Accepts a block of N FP16 operands, unpacks each operand and finds the block's maximum effective exponent.
- Emits each operand as a two's-complement fixed-point value aligned to that exponent, with the same signed_sum/exp_max format that normalization consumes.
- Sits between the operand buffer and the adder tree. Its output is the inverse mapping of normalization plus subnormal_handling.

---
 rtl/fp16_mac_pkg.sv | 23 ++
 rtl/fp16_unpack.sv | 43 ++++
 rtl/fp16_block_aligner.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fp16_mac_pkg.sv
// Shared FP16 field layout, alignment defaults and aligner state encoding.
package fp16_mac_pkg;

  localparam int FP16_W   = 16;
  localparam int EXP_W    = 5;
  localparam int FRAC_W   = 10;
  localparam int MANT_W   = 11;
  localparam int FRAC_LSB = 0;
  localparam int EXP_LSB  = 10;
  localparam int SIGN_BIT = 15;

  localparam logic [EXP_W-1:0] EXP_SPECIAL = 5'd31;

  localparam int N_DEF     = 9;
  localparam int SUM_W_DEF = 20;
  localparam int GUARD_DEF = 3;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } align_state_t;

endpackage

// File: rtl/fp16_unpack.sv
// Combinational FP16 unpack: sign, effective exponent, mantissa with hidden bit.
// Inf/NaN report is_special with a zero mantissa and e_eff=0 so they never
// raise the block maximum. With FP16_ALIGN_FTZ_EN defined, subnormals are
// flushed to zero and also excluded from the maximum.
module fp16_unpack
  import fp16_mac_pkg::*;
(
  input  logic [FP16_W-1:0] in_data,
  output logic              sign,
  output logic [5:0]        e_eff,
  output logic [MANT_W-1:0] mant,
  output logic              is_special
);

  logic [EXP_W-1:0]  exp_f;
  logic [FRAC_W-1:0] frac_f;

  assign exp_f  = in_data[EXP_LSB +: EXP_W];
  assign frac_f = in_data[FRAC_LSB +: FRAC_W];

  // Classify the exponent field and build the effective exponent/mantissa.
  always_comb begin
    sign       = in_data[SIGN_BIT];
    is_special = 1'b0;
    e_eff      = {1'b0, exp_f};
    mant       = {1'b1, frac_f};
    if (exp_f == EXP_SPECIAL) begin
      is_special = 1'b1;
      e_eff      = 6'd0;
      mant       = '0;
    end else if (exp_f == '0) begin
      e_eff = 6'd1;
      mant  = {1'b0, frac_f};
`ifdef FP16_ALIGN_FTZ_EN
      if (frac_f != '0) begin
        e_eff = 6'd0;
        mant  = '0;
      end
`endif
    end
  end

endmodule

// File: rtl/fp16_block_aligner.sv
// Block aligner: collects N FP16 operands, finds the block maximum effective
// exponent, then emits each operand as a signed fixed-point value aligned to
// that exponent. Optional build macro FP16_ALIGN_FTZ_EN flushes subnormals.
//
// state   | meaning
// COLLECT | accept operands into the buffer, track max exponent and specials
// EMIT    | present aligned operand idx; advance on each output handshake
module fp16_block_aligner
  import fp16_mac_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int SUM_W = SUM_W_DEF,
  parameter int GUARD = GUARD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [5:0]       out_exp_max,
  output logic             out_last,
  output logic             out_special
);

  localparam int               CNT_W    = (N > 1) ? $clog2(N) : 1;
  localparam int               MAG_W    = MANT_W + GUARD;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);
  localparam logic [5:0]       MAG_W_S  = 6'(MAG_W);

  align_state_t      state, state_nxt;
  logic [CNT_W-1:0]  count, idx;
  logic [5:0]        max_exp;
  logic              special;
  logic [15:0]       op_buf [N];

  logic              in_fire, out_fire;

  logic              unused_in_sign;
  logic [MANT_W-1:0] unused_in_mant;
  logic [5:0]        in_e_eff;
  logic              in_is_special;

  logic [15:0]       em_data;
  logic              em_sign;
  logic [5:0]        em_e_eff;
  logic [MANT_W-1:0] em_mant;
  logic              em_is_special;

  logic [5:0]        shift;
  logic [MAG_W-1:0]  aligned, mag;
  logic [SUM_W-1:0]  mag_ext, sum_val;

  fp16_unpack u_unpack_in (
    .in_data    (in_data),
    .sign       (unused_in_sign),
    .e_eff      (in_e_eff),
    .mant       (unused_in_mant),
    .is_special (in_is_special)
  );

  assign em_data = op_buf[idx];

  fp16_unpack u_unpack_em (
    .in_data    (em_data),
    .sign       (em_sign),
    .e_eff      (em_e_eff),
    .mant       (em_mant),
    .is_special (em_is_special)
  );

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && count == LAST_IDX) state_nxt = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && idx == LAST_IDX) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // Operand buffer, block maximum, special flag and the two indices.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      idx     <= '0;
      max_exp <= '0;
      special <= 1'b0;
    end else begin
      if (in_fire) begin
        op_buf[count] <= in_data;
        if (in_e_eff > max_exp) max_exp <= in_e_eff;
        special <= special | in_is_special;
        if (count == LAST_IDX) begin
          count <= '0;
          idx   <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end
      if (out_fire) begin
        if (idx == LAST_IDX) begin
          idx     <= '0;
          max_exp <= '0;
          special <= 1'b0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  // Align the current element to the block maximum and apply its sign.
  // Specials carry a zero mantissa, so their shift amount is irrelevant.
  always_comb begin
    shift   = max_exp - em_e_eff;
    aligned = {em_mant, {GUARD{1'b0}}};
    mag     = (shift >= MAG_W_S) ? '0 : (aligned >> shift);
    mag_ext = {{(SUM_W-MAG_W){1'b0}}, mag};
    sum_val = em_sign ? (-mag_ext) : mag_ext;
  end

  assign out_sum     = out_valid ? sum_val : '0;
  assign out_exp_max = out_valid ? max_exp : '0;
  assign out_last    = out_valid && (idx == LAST_IDX);
  assign out_special = out_valid && special;

endmodule
